regfile_multiport: RTL and testbench

//  Parametrised integer register file for the multicycle RISC-V core; successor to the fixed 32x32 2-read file.

---
 rtl/regfile_multiport.sv | 107 ++++++++++
 tb/tb_regfile_multiport.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with combinational reads, one synchronous write port,
// optional write-to-read bypass and hardwired zero entry, plus a post-reset clear sequencer.
module regfile_multiport #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    output logic                  busy,
    output logic                  clr_done
);

    // Index width actually needed to address NREGS entries (never wider than AW).
    localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            clr_last;
    logic            wr_go;
    logic            mem_we;
    logic [IW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;

    assign busy     = (state_q == StClear);
    assign clr_last = (clr_cnt_q == AW'(NREGS - 1));
    assign clr_done = busy && clr_last;

    assign wr_go = (state_q == StReady) && we && (32'(wa) < NREGS)
                   && !((ZERO_REG != 0) && (wa == '0));

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == StClear) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_last) begin
                state_d = StReady;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The clear sequencer owns the write port while busy; reset blocks all storage updates.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa[IW-1:0];
        mem_wd = wd;
        if (!reset) begin
            if (busy) begin
                mem_we = 1'b1;
                mem_wa = clr_cnt_q[IW-1:0];
                mem_wd = '0;
            end else if (wr_go) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = ra[g*AW +: AW];

        always_comb begin
            data = '0;
            if (!busy && (32'(addr) < NREGS) && !((ZERO_REG != 0) && (addr == '0))) begin
                if ((BYPASS != 0) && wr_go && (wa == addr)) begin
                    data = wd;
                end else begin
                    data = mem_q[addr[IW-1:0]];
                end
            end
        end

        assign rd[g*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised self-checking bench: two register file configurations share write/reset stimulus
// and are compared each cycle against an array-based reference model.
module tb_regfile_multiport;

    logic         clk = 1'b0;
    logic         reset;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [9:0]   ra_a;
    logic [19:0]  ra_b;
    logic [63:0]  rd_a;
    logic [127:0] rd_b;
    logic         busy_a, busy_b, done_a, done_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: instance 0 = 32 entries with bypass, instance 1 = 16 entries without.
    logic [31:0] mdl_mem [2][32];
    int          mdl_cyc [2];
    int          mdl_nregs [2] = '{32, 16};
    bit          mdl_byp [2]   = '{1'b1, 1'b0};
    bit          chk_en;
    int          done_cnt_a;

    always #5 clk = ~clk;

    regfile_multiport #(
        .XLEN(32), .NREGS(32), .AW(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .ra(ra_a), .rd(rd_a), .we(we), .wa(wa), .wd(wd),
        .busy(busy_a), .clr_done(done_a)
    );

    regfile_multiport #(
        .XLEN(32), .NREGS(16), .AW(5), .NREAD(4), .ZERO_REG(1), .BYPASS(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .ra(ra_b), .rd(rd_b), .we(we), .wa(wa), .wd(wd),
        .busy(busy_b), .clr_done(done_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_read(input int k, input logic [4:0] addr);
        int a;
        int w;
        a = int'(addr);
        w = int'(wa);
        if (mdl_cyc[k] < mdl_nregs[k]) return 32'h0;
        if (a >= mdl_nregs[k] || a == 0) return 32'h0;
        if (mdl_byp[k] && we && w == a) return wd;
        return mdl_mem[k][a];
    endfunction

    task automatic mdl_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mdl_cyc[k] = 0;
                for (int e = 0; e < 32; e++) mdl_mem[k][e] = 32'h0;
            end else if (mdl_cyc[k] < mdl_nregs[k]) begin
                mdl_cyc[k]++;
            end else if (we && int'(wa) < mdl_nregs[k] && wa != 5'd0) begin
                mdl_mem[k][int'(wa)] = wd;
            end
        end
    endtask

    task automatic cycle(input logic rst_v, input logic we_v, input logic [4:0] wa_v,
                         input logic [31:0] wd_v, input logic [9:0] ra_a_v,
                         input logic [19:0] ra_b_v);
        @(negedge clk);
        reset = rst_v;
        we    = we_v;
        wa    = wa_v;
        wd    = wd_v;
        ra_a  = ra_a_v;
        ra_b  = ra_b_v;
        #2;
        if (chk_en) begin
            check_eq("busy_a", {31'b0, busy_a}, {31'b0, mdl_cyc[0] < 32});
            check_eq("clr_done_a", {31'b0, done_a}, {31'b0, mdl_cyc[0] == 31});
            check_eq("busy_b", {31'b0, busy_b}, {31'b0, mdl_cyc[1] < 16});
            check_eq("clr_done_b", {31'b0, done_b}, {31'b0, mdl_cyc[1] == 15});
            for (int i = 0; i < 2; i++)
                check_eq($sformatf("rd_a%0d@%0d", i, ra_a_v[i*5 +: 5]), rd_a[i*32 +: 32],
                         mdl_read(0, ra_a_v[i*5 +: 5]));
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("rd_b%0d@%0d", i, ra_b_v[i*5 +: 5]), rd_b[i*32 +: 32],
                         mdl_read(1, ra_b_v[i*5 +: 5]));
        end
        if (done_a === 1'b1) done_cnt_a++;
        @(posedge clk);
        mdl_step();
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom()), $urandom(),
                  10'($urandom()), 20'($urandom()));
    endtask

    initial begin
        chk_en = 1'b0;
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra_a = '0; ra_b = '0;
        done_cnt_a = 0;
        mdl_cyc[0] = 0;
        mdl_cyc[1] = 0;

        cycle(1'b1, 1'b0, 5'd0, 32'h0, 10'h0, 20'h0);
        chk_en = 1'b1;

        // Clear sequence with writes attempted while busy.
        for (int c = 0; c < 34; c++)
            cycle(1'b0, 1'(c < 10), 5'd3, 32'hFF, 10'($urandom()), 20'($urandom()));
        check_eq("clr_done_pulses", 32'(done_cnt_a), 32'd1);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, {5'd3, 5'd3}, {4{5'd3}});

        // Write/read and zero-register behaviour.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, {5'd1, 5'd2}, {4{5'd9}});
        cycle(1'b0, 1'b0, 5'd0, 32'h0, {5'd0, 5'd5}, {5'd0, 5'd0, 5'd0, 5'd5});
        cycle(1'b0, 1'b1, 5'd0, 32'h1, {5'd0, 5'd0}, {4{5'd0}});
        cycle(1'b0, 1'b0, 5'd0, 32'h0, {5'd0, 5'd0}, {4{5'd0}});

        // Same-cycle bypass vs. old value.
        cycle(1'b0, 1'b1, 5'd7, 32'h12345678, {5'd0, 5'd7}, {15'd0, 5'd7});
        cycle(1'b0, 1'b0, 5'd0, 32'h0, {5'd7, 5'd7}, {4{5'd7}});

        // Out-of-range write on the 16-entry file, then four simultaneous reads.
        cycle(1'b0, 1'b1, 5'd20, 32'hA5A5A5A5, {5'd20, 5'd20}, {4{5'd20}});
        cycle(1'b0, 1'b0, 5'd0, 32'h0, {5'd20, 5'd20}, {4{5'd20}});
        cycle(1'b0, 1'b1, 5'd1, 32'h11111111, 10'h0, 20'h0);
        cycle(1'b0, 1'b1, 5'd2, 32'h22222222, 10'h0, 20'h0);
        cycle(1'b0, 1'b1, 5'd3, 32'h33333333, 10'h0, 20'h0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, {5'd2, 5'd1}, {5'd1, 5'd3, 5'd2, 5'd1});

        rand_cycles(400);

        // Reset mid-clear restarts the sequence with a single completion pulse.
        done_cnt_a = 0;
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 10'h0, 20'h0);
        rand_cycles(10);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 10'h0, 20'h0);
        rand_cycles(34);
        check_eq("clr_done_pulses_restart", 32'(done_cnt_a), 32'd1);

        rand_cycles(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
